// File: rtl/ball_collision_detect.sv
`default_nettype none
// ============================================================================
// Module      : ball_collision_detect
// Description : Once per frame tick, latches three ball centres and tests the
//               pairs 1-2, 1-3 and 2-3 in sequence on one shared
//               square-and-sum datapath. A pair overlaps when its squared
//               centre distance is <= (2*BALL_R)^2. Only contacts that were
//               not already present on the previous pass are reported in
//               flag, so a resting overlap does not re-trigger a bounce.
// Ports       : clk        - system clock
//               rst        - synchronous active-high reset
//               frame_tick - one-cycle pulse requesting a detection pass
//               bN_x, bN_y - ball N centre (unsigned, POS_W bits)
//               flag       - 3'b011 new 1-2, 3'b101 new 1-3, 3'b110 new 2-3
//               pair_mask  - raw overlap: bit0 1-2, bit1 1-3, bit2 2-3
//               flag_valid - one-cycle pulse when flag/pair_mask update
//               busy       - high while a pass is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module ball_collision_detect #(
    parameter int POS_W  = 10,
    parameter int BALL_R = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic [POS_W-1:0] b1_x,
    input  logic [POS_W-1:0] b1_y,
    input  logic [POS_W-1:0] b2_x,
    input  logic [POS_W-1:0] b2_y,
    input  logic [POS_W-1:0] b3_x,
    input  logic [POS_W-1:0] b3_y,
    output logic [2:0]       flag,
    output logic [2:0]       pair_mask,
    output logic             flag_valid,
    output logic             busy
);

    localparam int SQ_W  = 2 * POS_W;
    localparam int SUM_W = 2 * POS_W + 1;

    localparam int              c_THRESH_I = 4 * BALL_R * BALL_R;
    localparam logic [SUM_W-1:0] c_THRESH  = SUM_W'(c_THRESH_I);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_D12  = 3'd1;
    localparam logic [2:0] c_S12  = 3'd2;
    localparam logic [2:0] c_D13  = 3'd3;
    localparam logic [2:0] c_S13  = 3'd4;
    localparam logic [2:0] c_D23  = 3'd5;
    localparam logic [2:0] c_S23  = 3'd6;
    localparam logic [2:0] c_DONE = 3'd7;

    logic [2:0]       r_state;
    logic [POS_W-1:0] r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
    logic [POS_W-1:0] r_dx, r_dy;
    logic [1:0]       r_ov;     // overlap results of pairs 1-2 and 1-3
    logic [2:0]       r_prev;   // overlap set seen on the previous pass

    logic [POS_W-1:0] w_xa, w_xb, w_ya, w_yb;
    logic [POS_W-1:0] w_dx, w_dy;
    logic [SQ_W-1:0]  w_sq_x, w_sq_y;
    logic [SUM_W-1:0] w_sum;
    logic             w_hit;
    logic [2:0]       w_ov_all;
    logic [2:0]       w_new;
    logic [2:0]       w_flag;

    // Operand select for the shared difference stage, keyed by the D state.
    always_comb begin
        w_xa = r_x1;
        w_ya = r_y1;
        w_xb = r_x2;
        w_yb = r_y2;
        case (r_state)
            c_D13: begin
                w_xb = r_x3;
                w_yb = r_y3;
            end
            c_D23: begin
                w_xa = r_x2;
                w_ya = r_y2;
                w_xb = r_x3;
                w_yb = r_y3;
            end
            default: ;
        endcase
    end

    // Subtract the smaller from the larger so the difference never wraps.
    assign w_dx = (w_xa >= w_xb) ? (w_xa - w_xb) : (w_xb - w_xa);
    assign w_dy = (w_ya >= w_yb) ? (w_ya - w_yb) : (w_yb - w_ya);

    // Full-width squares and sum: a maximum-span pair cannot overflow.
    assign w_sq_x = {{POS_W{1'b0}}, r_dx} * {{POS_W{1'b0}}, r_dx};
    assign w_sq_y = {{POS_W{1'b0}}, r_dy} * {{POS_W{1'b0}}, r_dy};
    assign w_sum  = {1'b0, w_sq_x} + {1'b0, w_sq_y};
    assign w_hit  = (w_sum <= c_THRESH);

    // In S23 the 2-3 result is still combinational; fold it in directly so
    // the outputs can be registered on the edge that enters DONE.
    assign w_ov_all = {w_hit, r_ov};
    assign w_new    = w_ov_all & ~r_prev;

    always_comb begin
        w_flag = 3'b000;
        if (w_new[0]) begin
            w_flag = 3'b011;
        end else if (w_new[1]) begin
            w_flag = 3'b101;
        end else if (w_new[2]) begin
            w_flag = 3'b110;
        end
    end

    assign busy = (r_state != c_IDLE) && (r_state != c_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_x1       <= '0;
            r_y1       <= '0;
            r_x2       <= '0;
            r_y2       <= '0;
            r_x3       <= '0;
            r_y3       <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_ov       <= '0;
            r_prev     <= '0;
            flag       <= '0;
            pair_mask  <= '0;
            flag_valid <= 1'b0;
        end else begin
            flag_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (frame_tick) begin
                        r_x1    <= b1_x;
                        r_y1    <= b1_y;
                        r_x2    <= b2_x;
                        r_y2    <= b2_y;
                        r_x3    <= b3_x;
                        r_y3    <= b3_y;
                        r_state <= c_D12;
                    end
                end
                c_D12: begin
                    r_dx    <= w_dx;
                    r_dy    <= w_dy;
                    r_state <= c_S12;
                end
                c_S12: begin
                    r_ov[0] <= w_hit;
                    r_state <= c_D13;
                end
                c_D13: begin
                    r_dx    <= w_dx;
                    r_dy    <= w_dy;
                    r_state <= c_S13;
                end
                c_S13: begin
                    r_ov[1] <= w_hit;
                    r_state <= c_D23;
                end
                c_D23: begin
                    r_dx    <= w_dx;
                    r_dy    <= w_dy;
                    r_state <= c_S23;
                end
                c_S23: begin
                    // Results land together with the DONE state so they are
                    // visible, with the flag_valid pulse, during DONE.
                    flag       <= w_flag;
                    pair_mask  <= w_ov_all;
                    r_prev     <= w_ov_all;
                    flag_valid <= 1'b1;
                    r_state    <= c_DONE;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ball_collision_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_collision_detect
// Description : Self-checking bench for ball_collision_detect. A pass-level
//               model predicts busy/flag_valid/flag/pair_mask every cycle;
//               directed passes pin the model with hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_collision_detect;

    localparam int POS_W  = 10;
    localparam int BALL_R = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_tick;
    logic [POS_W-1:0] b1_x, b1_y, b2_x, b2_y, b3_x, b3_y;
    logic [2:0]       flag;
    logic [2:0]       pair_mask;
    logic             flag_valid;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_fv  = 0;

    ball_collision_detect #(
        .POS_W  (POS_W),
        .BALL_R (BALL_R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .b1_x       (b1_x),
        .b1_y       (b1_y),
        .b2_x       (b2_x),
        .b2_y       (b2_y),
        .b3_x       (b3_x),
        .b3_y       (b3_y),
        .flag       (flag),
        .pair_mask  (pair_mask),
        .flag_valid (flag_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- pass-level reference model ----------------
    function automatic bit touch(input int ax, input int ay, input int bx, input int by);
        return ((ax - bx) * (ax - bx) + (ay - by) * (ay - by)) <= (2 * BALL_R) * (2 * BALL_R);
    endfunction

    // Pass progress: 0 idle, 1..6 busy cycles, 7 result cycle.
    int         m_cnt  = 0;
    int         m_c[6];
    logic [2:0] m_prev = '0;
    logic [2:0] m_flag = '0;
    logic [2:0] m_mask = '0;
    logic       m_fv   = 1'b0;
    bit         chk_en = 1'b0;

    always @(negedge clk) begin
        logic [2:0] ov;
        logic [2:0] nw;
        if (flag_valid === 1'b1) n_fv++;
        if (chk_en) begin
            chk("busy",       {31'd0, busy},       {31'd0, (m_cnt >= 1 && m_cnt <= 6)});
            chk("flag_valid", {31'd0, flag_valid}, {31'd0, m_fv});
            chk("flag",       {29'd0, flag},       {29'd0, m_flag});
            chk("pair_mask",  {29'd0, pair_mask},  {29'd0, m_mask});
        end
        // advance to the next cycle using this cycle's inputs
        if (rst) begin
            m_cnt  = 0;
            m_prev = '0;
            m_flag = '0;
            m_mask = '0;
            m_fv   = 1'b0;
            chk_en = 1'b1;
        end else if (m_cnt == 0) begin
            m_fv = 1'b0;
            if (frame_tick) begin
                m_c[0] = int'(b1_x); m_c[1] = int'(b1_y);
                m_c[2] = int'(b2_x); m_c[3] = int'(b2_y);
                m_c[4] = int'(b3_x); m_c[5] = int'(b3_y);
                m_cnt  = 1;
            end
        end else if (m_cnt < 6) begin
            m_cnt++;
        end else if (m_cnt == 6) begin
            ov[0] = touch(m_c[0], m_c[1], m_c[2], m_c[3]);
            ov[1] = touch(m_c[0], m_c[1], m_c[4], m_c[5]);
            ov[2] = touch(m_c[2], m_c[3], m_c[4], m_c[5]);
            nw    = ov & ~m_prev;
            m_flag = nw[0] ? 3'b011 : nw[1] ? 3'b101 : nw[2] ? 3'b110 : 3'b000;
            m_mask = ov;
            m_prev = ov;
            m_fv   = 1'b1;
            m_cnt  = 7;
        end else begin
            m_fv  = 1'b0;
            m_cnt = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_cycle(input logic t, input logic r);
        @(posedge clk);
        #1;
        frame_tick = t;
        rst        = r;
    endtask

    task automatic set_coords(input int x1, input int y1, input int x2, input int y2,
                              input int x3, input int y3);
        b1_x = POS_W'(x1); b1_y = POS_W'(y1);
        b2_x = POS_W'(x2); b2_y = POS_W'(y2);
        b3_x = POS_W'(x3); b3_y = POS_W'(y3);
    endtask

    // One pass: tick, scramble coordinates mid-pass, find the result pulse.
    task automatic do_pass(input string nm, input int x1, input int y1, input int x2,
                           input int y2, input int x3, input int y3,
                           input logic [2:0] ef, input logic [2:0] em);
        int lat;
        @(posedge clk);
        #1;
        set_coords(x1, y1, x2, y2, x3, y3);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        set_coords(200, 200, 200, 200, 200, 200);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (flag_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_latency"}, 32'(lat), 32'd7);
        chk({nm, "_flag"},    {29'd0, flag},      {29'd0, ef});
        chk({nm, "_mask"},    {29'd0, pair_mask}, {29'd0, em});
    endtask

    initial begin
        int fv0;
        rst        = 1'b1;
        frame_tick = 1'b0;
        set_coords(0, 0, 0, 0, 0, 0);
        drive_cycle(0, 1);
        drive_cycle(0, 0);
        fv0 = n_fv;
        repeat (20) drive_cycle(0, 0);
        @(negedge clk);
        chk("idle_flag",   {29'd0, flag},      32'd0);
        chk("idle_mask",   {29'd0, pair_mask}, 32'd0);
        chk("idle_busy",   {31'd0, busy},      32'd0);
        chk("idle_pulses", 32'(n_fv - fv0),    32'd0);

        do_pass("far",      100, 100, 300, 100, 500, 300, 3'b000, 3'b000);
        do_pass("thr256",   200, 200, 216, 200, 500, 300, 3'b011, 3'b001);
        do_pass("thr289",   200, 200, 217, 200, 500, 300, 3'b000, 3'b000);
        do_pass("diag225",  200, 200, 209, 212, 500, 300, 3'b011, 3'b001);
        do_pass("sep0",     200, 200, 300, 200, 500, 300, 3'b000, 3'b000);
        do_pass("persist1", 200, 200, 210, 200, 500, 300, 3'b011, 3'b001);
        do_pass("persist2", 200, 200, 210, 200, 500, 300, 3'b000, 3'b001);
        do_pass("persist3", 200, 200, 210, 200, 500, 300, 3'b000, 3'b001);
        do_pass("sep1",     200, 200, 300, 200, 500, 300, 3'b000, 3'b000);
        do_pass("recontact",200, 200, 210, 200, 500, 300, 3'b011, 3'b001);
        do_pass("far2",     100, 100, 300, 100, 500, 300, 3'b000, 3'b000);
        do_pass("prio1",    200, 200, 208, 200, 204, 206, 3'b011, 3'b111);
        do_pass("prio2",    200, 200, 208, 200, 204, 206, 3'b000, 3'b111);
        do_pass("span",     0, 0, 1023, 1023, 0, 1023,    3'b000, 3'b000);
        do_pass("edge23",   0, 0, 1023, 1023, 1023, 1015, 3'b110, 3'b100);
        do_pass("new13",    0, 0, 1023, 1023, 10, 0,      3'b101, 3'b010);
        do_pass("tie",      0, 0, 20, 0, 10, 0,           3'b110, 3'b110);

        // Extra ticks while busy (T+3) and in the result cycle (T+7).
        @(posedge clk);
        #1;
        set_coords(200, 200, 210, 200, 500, 300);
        fv0 = n_fv;
        frame_tick = 1'b1;           // cycle T
        drive_cycle(0, 0);
        drive_cycle(0, 0);
        drive_cycle(1, 0);           // T+3
        drive_cycle(0, 0);
        drive_cycle(0, 0);
        drive_cycle(0, 0);
        drive_cycle(1, 0);           // T+7
        repeat (9) drive_cycle(0, 0);
        @(negedge clk);
        chk("drop_pulses", 32'(n_fv - fv0),    32'd1);
        chk("drop_flag",   {29'd0, flag},      32'h3);
        chk("drop_mask",   {29'd0, pair_mask}, 32'h1);

        // Reset in the middle of a pass.
        fv0 = n_fv;
        drive_cycle(1, 0);           // T
        drive_cycle(0, 0);
        drive_cycle(0, 0);
        drive_cycle(0, 0);
        drive_cycle(0, 1);           // T+4
        drive_cycle(0, 0);           // T+5
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (7) drive_cycle(0, 0);
        @(negedge clk);
        chk("rst_pulses", 32'(n_fv - fv0),    32'd0);
        chk("rst_flag",   {29'd0, flag},      32'd0);
        chk("rst_mask",   {29'd0, pair_mask}, 32'd0);
        do_pass("after_rst", 200, 200, 210, 200, 500, 300, 3'b011, 3'b001);

        repeat (4) drive_cycle(0, 0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/ball_collision_detect.md
Name: ball_collision_detect

Overview:
- Upstream stage of the collision direction update block: decides which balls touch and produces its 3-bit FLAG (bit0 = ball 1, bit1 = ball 2, bit2 = ball 3).
- Once per frame tick it latches the three ball centres and tests the pairs 1-2, 1-3 and 2-3 in sequence.
- Each test uses one shared square-and-sum datapath and compares squared centre distance against (2*BALL_R)^2.
- Reports only newly started contacts, so a pair still overlapping on later frames does not re-trigger a bounce.

Parameters:
POS_W, 10, width of each unsigned ball-centre coordinate (x and y).
BALL_R, 8, ball radius in pixels; contact threshold is (2*BALL_R)^2 = 256 by default.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
frame_tick  input  1  one-cycle pulse requesting a detection pass.
b1_x, b1_y  input  POS_W each  ball 1 centre.
b2_x, b2_y  input  POS_W each  ball 2 centre.
b3_x, b3_y  input  POS_W each  ball 3 centre.
flag  output  3  ball-pair flag for the direction update block; held between passes.
pair_mask  output  3  all pairs currently overlapping: bit0 = 1-2, bit1 = 1-3, bit2 = 2-3.
flag_valid  output  1  one-cycle pulse; flag and pair_mask updated this cycle.
busy  output  1  high while a pass is in progress.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: flag = 0, pair_mask = 0, flag_valid = 0, busy = 0. FSM goes to IDLE and all prev_overlap bits are cleared.
- FSM states: IDLE, D12, S12, D13, S13, D23, S23, DONE.

State transitions:
- IDLE: on frame_tick, latch all six coordinates at that edge and go to D12. busy is high from the next cycle.
- Dxy states: register dx = |xa - xb| and dy = |ya - yb| for the pair (POS_W bits each, unsigned, no wrap).
- Sxy states: compute sum = dx*dx + dy*dy (2*POS_W+1 bits, no truncation) and set ov_pair = (sum <= (2*BALL_R)^2). Touching counts as overlap.
- DONE: update the outputs, pulse flag_valid for one cycle, copy ov into prev_overlap, go to IDLE. busy is low in DONE.

Latency:
- frame_tick sampled in IDLE at cycle T: D12 at T+1, S23 at T+6, DONE at T+7.
- flag_valid is high during cycle T+7.
- Output values are valid from T+7 and held until the next DONE.

New-contact detection:
- new_pair = ov_pair AND NOT prev_overlap_pair.
- pair_mask = ov (raw overlap, regardless of history).

flag encoding:
- Priority 1-2 > 1-3 > 2-3; only the highest-priority new pair is reported.
- new 1-2: flag = 3'b011. new 1-3: flag = 3'b101. new 2-3: flag = 3'b110. None: flag = 3'b000.

Boundary conditions:
- frame_tick while busy (D12..S23): ignored, not queued.
- frame_tick in DONE: ignored.
- Coordinates changing mid-pass: no effect, since latched values are used.
- Coordinates at 0 or 2^POS_W-1: abs difference is exact; a maximum-span square does not overflow.
- rst in any state: next cycle is IDLE with reset values. Any in-progress pass is discarded with no flag_valid pulse, and prev_overlap is cleared.
- Pair separates (ov = 0): prev_overlap clears, so a later re-contact is reported again.

Test Plan:
- Reset then idle: hold rst 2 cycles, no ticks. Required: all outputs 0 and busy 0 for 20 cycles.
- Far apart, balls at (100,100), (300,100), (500,300); tick at T. Required: busy high T+1..T+6, flag_valid only at T+7, flag = 000, pair_mask = 000.
- Threshold: b1 (200,200), b2 (216,200) (sum = 256). Required: flag = 011, pair_mask = 001. Repeat with b2 (217,200) (sum = 289): flag = 000, pair_mask = 000. Diagonal b2 (209,212) (sum = 81+144 = 225): overlap.
- Persistence: b1 (200,200), b2 (210,200) over three ticks. Required: flag 011, then 000, then 000; pair_mask 001 on all three. Move b2 to (300,200) for one tick, then back to (210,200). Required: flag 011 again.
- Priority: all three balls at (200,200), (208,200), (204,206). Required: flag = 011, pair_mask = 111. Next tick: flag = 000, pair_mask = 111.
- Dropped tick and reset mid-pass: second tick at T+3 produces no extra flag_valid. A new pass with rst at T+4 gives no flag_valid at T+7 and busy = 0 at T+5. A fresh tick after reset re-reports an existing overlap as new.
